// File: rtl/branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// branch_predictor_btb
//   Branch target buffer with per-entry saturating direction counters. It
//   sits beside the IF-stage PC and predicts the next PC for branches and
//   jumps. The MEM stage trains it with resolved outcomes. It also flags
//   mispredicts and keeps a saturating mispredict count.
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   lk_pc_i       IF-stage PC to look up
//   lk_hit_o      lookup hit (valid entry with matching tag)
//   lk_taken_o    predicted taken (hit and counter MSB set)
//   lk_target_o   predicted next PC (entry target, else lk_pc_i + 4)
//   upd_valid_i   a branch/jump resolves this cycle
//   upd_pc_i      PC of the resolved instruction
//   upd_taken_i   actual outcome
//   upd_target_i  actual target (meaningful when taken)
//   upd_pred_i    prediction carried down the pipe with the instruction
//   upd_ptgt_i    predicted target carried down the pipe
//   inv_all_i     synchronous invalidate of every entry
//   mispredict_o  combinational: the resolved instruction was mispredicted
//   stat_miss_o   saturating count of mispredicts
// ---------------------------------------------------------------------------
module branch_predictor_btb #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   lk_pc_i,
  output logic              lk_hit_o,
  output logic              lk_taken_o,
  output logic [PC_W-1:0]   lk_target_o,
  input  logic              upd_valid_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [PC_W-1:0]   upd_target_i,
  input  logic              upd_pred_i,
  input  logic [PC_W-1:0]   upd_ptgt_i,
  input  logic              inv_all_i,
  output logic              mispredict_o,
  output logic [STAT_W-1:0] stat_miss_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  // Weak taken / weak not-taken encodings (1 / 0 when CTR_W == 1).
  localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_W'(2 ** (CTR_W - 1) - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Table held in flops so every entry can be cleared in one edge.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [STAT_W-1:0] stat_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;

  // Byte-offset bits of the update PC never address the table.
  logic              unused_pc_bits;
  assign unused_pc_bits = ^upd_pc_i[1:0];

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  // Address split: word index from the low PC bits, tag from the rest.
  always_comb begin
    lk_idx  = lk_pc_i[IDX_W+1:2];
    lk_tag  = lk_pc_i[PC_W-1:IDX_W+2];
    upd_idx = upd_pc_i[IDX_W+1:2];
    upd_tag = upd_pc_i[PC_W-1:IDX_W+2];
  end

  // Lookup reads pre-edge contents only; a same-cycle update is not bypassed.
  always_comb begin
    lk_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken_o  = lk_hit_o && ctr_q[lk_idx][CTR_W-1];
    lk_target_o = lk_taken_o ? target_q[lk_idx] : lk_pc_i + PC_W'(4);
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Wrong direction, or right "taken" call with the wrong target.
  always_comb begin
    mispredict_o = 1'b0;
    if (upd_valid_i) begin
      mispredict_o = (upd_pred_i != upd_taken_i) ||
                     (upd_taken_i && upd_pred_i && (upd_ptgt_i != upd_target_i));
    end
  end

  // Table training; invalidate-all takes priority over a same-cycle update.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (inv_all_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          ctr_q[upd_idx]    <= sat_inc(ctr_q[upd_idx]);
          target_q[upd_idx] <= upd_target_i;
        end else begin
          ctr_q[upd_idx]    <= sat_dec(ctr_q[upd_idx]);
        end
      end else if (upd_taken_i) begin
        // Only taken branches allocate; they replace whatever aliases there.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

  // Mispredict statistic, sticky at its maximum.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (mispredict_o && (stat_q != STAT_MAX)) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign stat_miss_o = stat_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_btb
//   Directed bench for branch_predictor_btb. Two instances share all inputs:
//   one with default parameters and one with STAT_W=2 for statistic
//   saturation. The driver pushes hand-computed expectations into a queue;
//   a monitor pops one per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_branch_predictor_btb;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lk_pc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_pred_i = 1'b0;
  logic [31:0] upd_ptgt_i = '0;
  logic        inv_all_i = 1'b0;

  logic        hit_a, taken_a, misp_a;
  logic [31:0] tgt_a;
  logic [15:0] stat_a;
  logic        hit_b, taken_b, misp_b;
  logic [31:0] tgt_b;
  logic [1:0]  stat_b;

  always #5 clk_i = ~clk_i;

  branch_predictor_btb u_dut (
    .clk_i(clk_i), .rst_n(rst_n), .lk_pc_i(lk_pc_i),
    .lk_hit_o(hit_a), .lk_taken_o(taken_a), .lk_target_o(tgt_a),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_i(upd_pred_i), .upd_ptgt_i(upd_ptgt_i),
    .inv_all_i(inv_all_i), .mispredict_o(misp_a), .stat_miss_o(stat_a)
  );

  branch_predictor_btb #(.STAT_W(2)) u_dut_s2 (
    .clk_i(clk_i), .rst_n(rst_n), .lk_pc_i(lk_pc_i),
    .lk_hit_o(hit_b), .lk_taken_o(taken_b), .lk_target_o(tgt_b),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_i(upd_pred_i), .upd_ptgt_i(upd_ptgt_i),
    .inv_all_i(inv_all_i), .mispredict_o(misp_b), .stat_miss_o(stat_b)
  );

  typedef struct {
    int          id;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        misp;
    logic [15:0] s16;
    logic [1:0]  s2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_n = 0;
  logic [15:0] m_s16 = '0;
  logic [1:0]  m_s2  = '0;

  task automatic cmp(input int id, input string what, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL v%0d %s got=%0h want=%0h", id, what, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.id, "hit",      32'(hit_a),   32'(e.hit));
        cmp(e.id, "taken",    32'(taken_a), 32'(e.taken));
        cmp(e.id, "target",   tgt_a,        e.tgt);
        cmp(e.id, "misp",     32'(misp_a),  32'(e.misp));
        cmp(e.id, "stat16",   32'(stat_a),  32'(e.s16));
        cmp(e.id, "hit_s2",   32'(hit_b),   32'(e.hit));
        cmp(e.id, "taken_s2", 32'(taken_b), 32'(e.taken));
        cmp(e.id, "target_s2", tgt_b,       e.tgt);
        cmp(e.id, "misp_s2",  32'(misp_b),  32'(e.misp));
        cmp(e.id, "stat2",    32'(stat_b),  32'(e.s2));
      end
    end
  end

  // Drive one cycle just after the rising edge and queue its expectation.
  task automatic step(input logic r, input logic [31:0] lk,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg, input logic up, input logic [31:0] upt,
                      input logic inv,
                      input logic eh, input logic et, input logic [31:0] etg,
                      input logic em);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_n = r; lk_pc_i = lk; upd_valid_i = uv; upd_pc_i = upc;
    upd_taken_i = ut; upd_target_i = utg; upd_pred_i = up; upd_ptgt_i = upt;
    inv_all_i = inv;
    if (!r) begin
      m_s16 = '0;
      m_s2  = '0;
    end
    vec_n++;
    e.id = vec_n; e.hit = eh; e.taken = et; e.tgt = etg; e.misp = em;
    e.s16 = m_s16; e.s2 = m_s2;
    exp_q.push_back(e);
    if (r && em) begin
      if (m_s16 != 16'hFFFF) m_s16 = m_s16 + 16'd1;
      if (m_s2 != 2'd3)      m_s2  = m_s2 + 2'd1;
    end
  endtask

  initial begin
    int waited;
    //    rst lk_pc         uv upd_pc      t  target       p  ptgt        inv  hit tk exp_tgt     misp
    step(0, 32'h40,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h44,  0); // reset state
    step(1, 32'h40,       1, 32'h40,   1, 32'h100, 0, 32'h44,  0,   0, 0, 32'h44,  1); // allocate 0x40
    step(1, 32'h40,       1, 32'h40,   1, 32'h100, 1, 32'h100, 0,   1, 1, 32'h100, 0); // ctr 2->3
    step(1, 32'h40,       1, 32'h40,   1, 32'h100, 1, 32'h100, 0,   1, 1, 32'h100, 0); // ctr stays 3
    step(1, 32'h40,       1, 32'h40,   0, 32'h0,   1, 32'h100, 0,   1, 1, 32'h100, 1); // NT: 3->2
    step(1, 32'h40,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h100, 0); // still taken
    step(1, 32'h40,       1, 32'h40,   0, 32'h0,   1, 32'h100, 0,   1, 1, 32'h100, 1); // NT: 2->1
    step(1, 32'h40,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 0, 32'h44,  0); // hit, not taken
    step(1, 32'h40,       1, 32'h40,   1, 32'h200, 1, 32'h100, 0,   1, 0, 32'h44,  1); // wrong target
    step(1, 32'h40,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h200, 0); // new target
    step(1, 32'h80,       0, 32'h80,   0, 32'h0,   1, 32'h0,   0,   0, 0, 32'h84,  0); // no upd: no misp
    step(1, 32'h40,       1, 32'h80,   1, 32'h300, 0, 32'h84,  0,   1, 1, 32'h200, 1); // alias evicts
    step(1, 32'h40,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h44,  0); // 0x40 gone
    step(1, 32'h80,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h300, 0); // 0x80 present
    step(1, 32'h40,       1, 32'h40,   1, 32'h500, 0, 32'h44,  0,   0, 0, 32'h44,  1); // no bypass
    step(1, 32'h40,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h500, 0); // visible next
    step(1, 32'h48,       1, 32'h48,   0, 32'h0,   0, 32'h4C,  0,   0, 0, 32'h4C,  0); // NT miss
    step(1, 32'h48,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h4C,  0); // not allocated
    step(1, 32'h40,       1, 32'h48,   1, 32'h600, 0, 32'h4C,  1,   1, 1, 32'h500, 1); // inv + upd
    step(1, 32'h40,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h44,  0); // table empty
    step(1, 32'h48,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h4C,  0); // upd discarded
    step(1, 32'h44,       1, 32'h44,   1, 32'h700, 0, 32'h48,  0,   0, 0, 32'h48,  1); // allocate 0x44
    step(1, 32'h44,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h700, 0); // hit 0x44
    step(0, 32'h44,       1, 32'h44,   0, 32'h0,   1, 32'h700, 0,   0, 0, 32'h48,  1); // async reset
    step(1, 32'h44,       1, 32'h44,   1, 32'h800, 0, 32'h48,  0,   0, 0, 32'h48,  1); // 1st edge updates
    step(1, 32'h44,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h800, 0); // trained
    step(1, 32'h46,       0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h800, 0); // pc[1:0] ignored
    step(1, 32'hFFFFFFFC, 0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h0,   0); // +4 wraps
    step(1, 32'h0,        0, 32'h0,    0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h4,   0); // idle
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk_i);
      waited++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
